mips_perf_monitor: RTL and testbench
====================================

Name: mips_perf_monitor

Overview:
- Synthesizable performance and sanity monitor for the 5-stage MIPS pipeline core.
- Sits beside the datapath and observes per-cycle event strobes from IF/WB and the hazard unit.
- Keeps saturating event counters, measures pipeline-fill latency, and latches the first misaligned-PC error.
- Counters are read through a registered select/read port, so software or a bench can read them without hierarchical probing.

Parameters:
- CNT_W, 32: width of every event counter and of rd_data (legal 8..64).
- PC_W, 32: width of observed PC and captured error PC.
- FILL_W, 8: width of fill-latency counter; saturates at all-ones.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse: begin a measurement window.
- stop  in  1  pulse: end the window and freeze counters.
- clear  in  1  pulse: zero all counters, fill_cycles and the error capture; state unchanged.
- if_pc  in  PC_W  PC presented to IF this cycle.
- if_valid  in  1  if_pc is a real fetch.
- wb_retire  in  1  one instruction retires in WB this cycle.
- stall  in  1  hazard unit is stalling IF/ID this cycle.
- flush  in  1  pipeline flush (branch/jump) this cycle.
- rd_sel  in  3  counter select.
- rd_data  out  CNT_W  registered read data.
- state_o  out  2  current FSM state.
- fill_cycles  out  FILL_W  cycles from start to first retire.
- align_err  out  1  sticky misaligned-PC flag.
- err_pc  out  PC_W  first misaligned if_pc seen.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all counters, fill_cycles, rd_data, align_err and err_pc are 0.
- FSM encoding: IDLE=0, FILL=1, RUN=2, HALT=3.
- IDLE: start goes to FILL; counters are held.
- FILL: counts cycle, stall and flush events. The first wb_retire moves to RUN, counts that retire, and freezes fill_cycles.
- RUN: counts cycle, retire, stall and flush events every cycle.
- HALT: counters are frozen; start goes to FILL with counters preserved (accumulating window).
- stop in FILL or RUN goes to HALT. stop in IDLE or HALT is ignored.
- start and stop in the same cycle: stop wins.
- fill_cycles:
  - Loads 1 in the cycle start is accepted.
  - Increments each FILL cycle and saturates.
  - If retire occurs in the first FILL cycle, fill_cycles = 1.
- Counters, indexed by rd_sel:
  - 0 = cycles (FILL or RUN)
  - 1 = retired
  - 2 = stall cycles
  - 3 = flush events
  - 4 = misaligned fetches
  - 5 = {CNT_W-FILL_W zeros, fill_cycles}
  - 6 = {CNT_W-2 zeros, state}
  - 7 = 0
- All counters saturate at 2^CNT_W-1 and never wrap.
- Events are counted only in FILL/RUN. The exception is the misalignment check.
- Misalignment check, active in every state: if_valid && if_pc[1:0]!=0 increments counter 4.
  - On the first such event, sets align_err and captures err_pc.
  - Later events do not overwrite err_pc.
- clear, any state, has priority over same-cycle increments: all counters, fill_cycles, align_err and err_pc become 0 next cycle.
- Read port: rd_data <= mux(rd_sel) each clk. Latency is 1 cycle, and the value reflects counters before the current cycle's increment.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Defined:
  - Extra input snap (1 bit).
  - A snap pulse copies counters 0..4 into shadow registers in the same edge, taken before same-cycle increments.
  - rd_sel[2]... is extended: an extra input rd_shadow selects shadow copies for sel 0..4.
  - clear also zeroes the shadows.
- Undefined: no snap/rd_shadow ports and no shadow registers. Behaviour is otherwise identical.

Decomposition:
- Package mips_perf_pkg holds:
  - state typedef (IDLE/FILL/RUN/HALT).
  - rd_sel index constants SEL_CYC, SEL_RET, SEL_STL, SEL_FLS, SEL_ALN, SEL_FILL, SEL_STATE.
- One natural sub-module: perf_sat_counter (params W; ports clk, reset_n, clr, inc, q), instantiated five times.

Test Plan:
- Reset and fill: reset_n low 2 cycles, then high; start pulse; wb_retire first high 4 cycles after start. Required: fill_cycles=5, state RUN, rd_sel=1 reads 1 one cycle later.
- Counting and freeze: run 100 cycles in RUN with stall high 10 cycles and flush 3 pulses, then stop. Required: sel0=100+fill, sel2=10, sel3=3, state HALT. 5 more cycles leave all values unchanged.
- Misaligned PC: if_valid with if_pc=0x0000_0042 while IDLE, then 0x0000_0081. Required: align_err=1, err_pc=0x42, sel4=2.
- Saturation: CNT_W=8, run 300 cycles. Required: sel0=0xFF, no wrap.
- clear, and start+stop: clear together with wb_retire gives sel1=0. start and stop in the same cycle in IDLE: state stays IDLE. In RUN: goes to HALT.
- Snapshot (PERF_SNAPSHOT_EN): snap at retired=7 together with one retire. Required: shadow sel1=7, live=8.

Source files
------------

// File: rtl/mips_perf_pkg.sv
// mips_perf_pkg: shared types and constants for the MIPS performance monitor.
//   perf_state_e : monitor FSM state (IDLE/FILL/RUN/HALT).
//   SEL_*        : rd_sel indices of the read port.
//   NUM_CNT      : number of saturating event counters (selects 0..4).
package mips_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } perf_state_e;

  localparam logic [2:0] SEL_CYC   = 3'd0;
  localparam logic [2:0] SEL_RET   = 3'd1;
  localparam logic [2:0] SEL_STL   = 3'd2;
  localparam logic [2:0] SEL_FLS   = 3'd3;
  localparam logic [2:0] SEL_ALN   = 3'd4;
  localparam logic [2:0] SEL_FILL  = 3'd5;
  localparam logic [2:0] SEL_STATE = 3'd6;

  localparam int NUM_CNT = 5;

endpackage

// File: rtl/mips_perf_monitor_sat_counter.sv
// perf_sat_counter: W-bit event counter that sticks at all-ones.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous zero, wins over inc
//   inc          : count one event this cycle
//   q            : current count
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + 1'b1;
  end

endmodule

// File: rtl/mips_perf_monitor.sv
// mips_perf_monitor: event counters, fill latency and misaligned-PC capture
// for the 5-stage MIPS pipeline.
//   clk, reset_n            : clock, async active-low reset
//   start/stop/clear        : window control pulses (stop beats start)
//   if_pc/if_valid          : fetch observed in IF
//   wb_retire/stall/flush   : per-cycle pipeline event strobes
//   rd_sel -> rd_data       : registered counter read, 1-cycle latency
//   state_o, fill_cycles    : FSM state, cycles from start to first retire
//   align_err, err_pc       : sticky misaligned-fetch flag and first bad PC
// Build option PERF_SNAPSHOT_EN adds snap (copy counters 0..4 into shadow
// registers) and rd_shadow (read shadows for rd_sel 0..4).
module mips_perf_monitor
  import mips_perf_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int PC_W   = 32,
  parameter int FILL_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              if_valid,
  input  logic              wb_retire,
  input  logic              stall,
  input  logic              flush,
`ifdef PERF_SNAPSHOT_EN
  input  logic              snap,
  input  logic              rd_shadow,
`endif
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [1:0]        state_o,
  output logic [FILL_W-1:0] fill_cycles,
  output logic              align_err,
  output logic [PC_W-1:0]   err_pc
);

  perf_state_e state;
  logic [1:0]  state_bits;
  logic        active, start_ok, aln_ev;
  logic [NUM_CNT-1:0]            inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;

  assign state_bits = state;
  assign state_o    = state_bits;
  assign active     = (state == FILL) || (state == RUN);
  // start is only taken from IDLE/HALT and only when stop is not also high
  assign start_ok   = start && !stop && ((state == IDLE) || (state == HALT));
  // alignment is checked in every state, unlike the windowed events
  assign aln_ev     = if_valid && (if_pc[1:0] != 2'b00);

  assign inc[SEL_CYC] = active;
  assign inc[SEL_RET] = active && wb_retire;
  assign inc[SEL_STL] = active && stall;
  assign inc[SEL_FLS] = active && flush;
  assign inc[SEL_ALN] = aln_ev;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_sat_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .inc     (inc[i]),
      .q       (cnt_q[i])
    );
  end

  // FSM plus fill latency; clear touches fill_cycles but never the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fill_cycles <= '0;
    end else begin
      case (state)
        IDLE:    if (start_ok) state <= FILL;
        FILL:    if (stop) state <= HALT;
                 else if (wb_retire) state <= RUN;
        RUN:     if (stop) state <= HALT;
        HALT:    if (start_ok) state <= FILL;
        default: state <= IDLE;
      endcase
      if (clear)
        fill_cycles <= '0;
      else if (start_ok)
        fill_cycles <= {{(FILL_W-1){1'b0}}, 1'b1};
      // the retiring FILL cycle is already covered, so the count freezes there
      else if ((state == FILL) && !wb_retire && (fill_cycles != '1))
        fill_cycles <= fill_cycles + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      align_err <= 1'b0;
      err_pc    <= '0;
    end else if (clear) begin
      align_err <= 1'b0;
      err_pc    <= '0;
    end else if (aln_ev && !align_err) begin
      align_err <= 1'b1;
      err_pc    <= if_pc;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [NUM_CNT-1:0][CNT_W-1:0] shadow;

  // snap samples the pre-increment counter values of this edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   shadow <= '0;
    else if (clear) shadow <= '0;
    else if (snap)  shadow <= cnt_q;
  end
`endif

  // read port samples pre-update values: same-edge increments show next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      case (rd_sel)
        SEL_CYC:   rd_data <= cnt_q[SEL_CYC];
        SEL_RET:   rd_data <= cnt_q[SEL_RET];
        SEL_STL:   rd_data <= cnt_q[SEL_STL];
        SEL_FLS:   rd_data <= cnt_q[SEL_FLS];
        SEL_ALN:   rd_data <= cnt_q[SEL_ALN];
        SEL_FILL:  rd_data <= CNT_W'(fill_cycles);
        SEL_STATE: rd_data <= CNT_W'(state_bits);
        default:   rd_data <= '0;
      endcase
`ifdef PERF_SNAPSHOT_EN
      if (rd_shadow) begin
        case (rd_sel)
          SEL_CYC: rd_data <= shadow[SEL_CYC];
          SEL_RET: rd_data <= shadow[SEL_RET];
          SEL_STL: rd_data <= shadow[SEL_STL];
          SEL_FLS: rd_data <= shadow[SEL_FLS];
          SEL_ALN: rd_data <= shadow[SEL_ALN];
          default: ;
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_mips_perf_monitor.sv
// Bench for mips_perf_monitor: a 32-bit and an 8-bit counter instance share
// one stimulus stream. A reference model (unbounded event totals, clamped to
// each instance's counter range) predicts every cycle's outputs into a queue;
// a monitor pops and compares after each rising edge.
module tb_mips_perf_monitor;

`ifdef PERF_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 0, stop = 0, clear = 0, if_valid = 0;
  logic        wb_retire = 0, stall = 0, flush = 0, snap = 0, rd_shadow = 0;
  logic [31:0] if_pc = '0;
  logic [2:0]  rd_sel = '0;

  logic [31:0] rd32, ep32, ep8;
  logic [7:0]  rd8, fill32, fill8;
  logic [1:0]  st32, st8;
  logic        ae32, ae8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_perf_monitor #(.CNT_W(32), .PC_W(32), .FILL_W(8)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .if_pc(if_pc), .if_valid(if_valid), .wb_retire(wb_retire), .stall(stall),
    .flush(flush),
`ifdef PERF_SNAPSHOT_EN
    .snap(snap), .rd_shadow(rd_shadow),
`endif
    .rd_sel(rd_sel), .rd_data(rd32), .state_o(st32), .fill_cycles(fill32),
    .align_err(ae32), .err_pc(ep32)
  );

  mips_perf_monitor #(.CNT_W(8), .PC_W(32), .FILL_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .if_pc(if_pc), .if_valid(if_valid), .wb_retire(wb_retire), .stall(stall),
    .flush(flush),
`ifdef PERF_SNAPSHOT_EN
    .snap(snap), .rd_shadow(rd_shadow),
`endif
    .rd_sel(rd_sel), .rd_data(rd8), .state_o(st8), .fill_cycles(fill8),
    .align_err(ae8), .err_pc(ep8)
  );

  // ---------------- reference model ----------------
  // Totals are kept unbounded; a saturating +1 counter equals min(total, max).
  longint unsigned m_cnt[5];
  longint unsigned m_shd[5];
  longint unsigned m_fill;
  int              m_st;     // 0 idle, 1 fill, 2 run, 3 halt
  bit              m_ae;
  logic [31:0]     m_ep;

  typedef struct {
    logic [31:0] rd32;
    logic [7:0]  rd8;
    logic [1:0]  st;
    logic [7:0]  fill;
    logic        ae;
    logic [31:0] ep;
  } exp_t;

  exp_t sb[$];

  function automatic longint unsigned sat(longint unsigned v, longint unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic longint unsigned rd_exp(int sel, longint unsigned mx, bit rs);
    if (sel < 5) return rs ? sat(m_shd[sel], mx) : sat(m_cnt[sel], mx);
    if (sel == 5) return sat(m_fill, 255);
    if (sel == 6) return longint'(m_st);
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin m_cnt[i] = 0; m_shd[i] = 0; end
    m_fill = 0; m_st = 0; m_ae = 0; m_ep = '0;
  endtask

  task automatic model_step(input bit st, sp, cl, v, ret, stl, fl,
                            input logic [31:0] pc, input bit sn);
    bit in_win = (m_st == 1) || (m_st == 2);
    bit go     = st && !sp && ((m_st == 0) || (m_st == 3));
    int nst    = m_st;
    if (sp && in_win)            nst = 3;
    else if (go)                 nst = 1;
    else if ((m_st == 1) && ret) nst = 2;
    if (cl) begin
      for (int i = 0; i < 5; i++) begin m_cnt[i] = 0; m_shd[i] = 0; end
      m_fill = 0; m_ae = 0; m_ep = '0;
    end else begin
      if (sn) for (int i = 0; i < 5; i++) m_shd[i] = m_cnt[i];
      if (in_win) begin
        m_cnt[0]++;
        if (ret) m_cnt[1]++;
        if (stl) m_cnt[2]++;
        if (fl)  m_cnt[3]++;
      end
      if (v && (pc[1:0] != 2'b00)) begin
        m_cnt[4]++;
        if (!m_ae) begin m_ae = 1; m_ep = pc; end
      end
      if (go) m_fill = 1;
      else if ((m_st == 1) && !ret) m_fill++;
    end
    m_st = nst;
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input bit st, sp, cl, v, ret, stl, fl,
                     input logic [31:0] pc, input logic [2:0] sel,
                     input bit sn, rs);
    exp_t e;
    bit   snx = sn && SNAP;
    bit   rsx = rs && SNAP;
    @(negedge clk);
    start = st; stop = sp; clear = cl; if_valid = v; wb_retire = ret;
    stall = stl; flush = fl; if_pc = pc; rd_sel = sel; snap = snx; rd_shadow = rsx;
    e.rd32 = 32'(rd_exp(int'(sel), 64'hFFFF_FFFF, rsx));
    e.rd8  = 8'(rd_exp(int'(sel), 64'hFF, rsx));
    model_step(st, sp, cl, v, ret, stl, fl, pc, snx);
    e.st   = 2'(m_st);
    e.fill = 8'(sat(m_fill, 255));
    e.ae   = m_ae;
    e.ep   = m_ep;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0,0,0,0,0,0,0, 32'h0, 3'd0, 0, 0);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  // Issue one read cycle and check its result against fixed values.
  task automatic rd_chk(input string name, input logic [2:0] sel, input bit rs,
                        input logic [31:0] want32, input logic [7:0] want8);
    cyc(0,0,0,0,0,0,0, 32'h0, sel, 0, rs);
    @(posedge clk); #2;
    cmp({name, " dut32"}, 64'(rd32), 64'(want32));
    cmp({name, " dut8"},  64'(rd8),  64'(want8));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start = 0; stop = 0; clear = 0; if_valid = 0; wb_retire = 0;
    stall = 0; flush = 0; if_pc = '0; rd_sel = '0; snap = 0; rd_shadow = 0;
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset rd32", 64'(rd32), 64'h0);
    cmp("reset rd8", 64'(rd8), 64'h0);
    cmp("reset state", 64'({st32, st8}), 64'h0);
    cmp("reset fill", 64'({fill32, fill8}), 64'h0);
    cmp("reset align_err", 64'({ae32, ae8}), 64'h0);
    cmp("reset err_pc", 64'({ep32, ep8}), 64'h0);
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("sb rd32", 64'(rd32), 64'(e.rd32));
        cmp("sb rd8", 64'(rd8), 64'(e.rd8));
        cmp("sb state", 64'({st32, st8}), 64'({e.st, e.st}));
        cmp("sb fill", 64'({fill32, fill8}), 64'({e.fill, e.fill}));
        cmp("sb align_err", 64'({ae32, ae8}), 64'({e.ae, e.ae}));
        cmp("sb err_pc32", 64'(ep32), 64'(e.ep));
        cmp("sb err_pc8", 64'(ep8), 64'(e.ep));
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // misaligned fetches while IDLE: first one is captured
    cyc(0,0,0,1,0,0,0, 32'h0000_0042, 3'd0, 0, 0);
    cyc(0,0,0,1,0,0,0, 32'h0000_0081, 3'd0, 0, 0);
    cyc(0,0,0,1,0,0,0, 32'h0000_0100, 3'd0, 0, 0);   // aligned, not counted
    @(posedge clk); #2;
    cmp("align_err", 64'(ae32), 64'h1);
    cmp("err_pc", 64'(ep32), 64'h42);
    rd_chk("misaligned count", 3'd4, 0, 32'd2, 8'd2);

    // fill: start, four FILL cycles without retire, retire on the fifth
    cyc(1,0,0,0,0,0,0, 32'h0, 3'd0, 0, 0);
    idle(4);
    cyc(0,0,0,0,1,0,0, 32'h0, 3'd0, 0, 0);
    rd_chk("retired after fill", 3'd1, 0, 32'd1, 8'd1);
    cmp("fill_cycles", 64'(fill32), 64'd5);
    cmp("state run", 64'(st32), 64'd2);

    // 100 RUN cycles in total (the read above, 98 here, the stop cycle)
    for (int i = 0; i < 98; i++)
      cyc(0,0,0,0,0, (i >= 10 && i < 20), (i == 30 || i == 50 || i == 70),
          32'h0, 3'd0, 0, 0);
    cyc(0,1,0,0,0,0,0, 32'h0, 3'd0, 0, 0);
    rd_chk("cycles at stop", 3'd0, 0, 32'd105, 8'd105);
    rd_chk("stall cycles", 3'd2, 0, 32'd10, 8'd10);
    rd_chk("flush events", 3'd3, 0, 32'd3, 8'd3);
    cmp("state halt", 64'(st32), 64'd3);
    idle(5);
    rd_chk("cycles frozen", 3'd0, 0, 32'd105, 8'd105);

    // resume from HALT with retire in the first FILL cycle, then saturate
    cyc(1,0,0,0,0,0,0, 32'h0, 3'd0, 0, 0);
    cyc(0,0,0,0,1,0,0, 32'h0, 3'd0, 0, 0);
    idle(300);
    rd_chk("cycles saturate", 3'd0, 0, 32'd406, 8'hFF);
    cmp("fill one", 64'(fill32), 64'd1);

    // clear beats a same-cycle retire
    cyc(0,0,1,0,1,0,0, 32'h0, 3'd0, 0, 0);
    rd_chk("retired after clear", 3'd1, 0, 32'd0, 8'd0);
    cmp("align_err cleared", 64'(ae32), 64'h0);

    // seven retires, then a snap together with the eighth
    for (int i = 0; i < 7; i++) cyc(0,0,0,0,1,0,0, 32'h0, 3'd0, 0, 0);
`ifdef PERF_SNAPSHOT_EN
    cyc(0,0,0,0,1,0,0, 32'h0, 3'd0, 1, 0);
    rd_chk("shadow retired", 3'd1, 1, 32'd7, 8'd7);
    rd_chk("live retired", 3'd1, 0, 32'd8, 8'd8);
`else
    cyc(0,0,0,0,1,0,0, 32'h0, 3'd0, 0, 0);
    rd_chk("live retired", 3'd1, 0, 32'd8, 8'd8);
`endif

    // start+stop together: RUN goes to HALT, IDLE stays IDLE
    cyc(1,1,0,0,0,0,0, 32'h0, 3'd0, 0, 0);
    @(posedge clk); #2;
    cmp("start+stop in run", 64'(st32), 64'd3);
    do_reset();
    cyc(1,1,0,0,0,0,0, 32'h0, 3'd0, 0, 0);
    @(posedge clk); #2;
    cmp("start+stop in idle", 64'(st32), 64'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, pc, 3'($urandom_range(0, 7)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end

    @(posedge clk); #3;
    cmp("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog: the sequence above takes roughly 2100 cycles
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
